// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing blocks: the window scheduler
// FSM state encoding and the index-width helper used to size column/row ports.
package img_proc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRIME  = 3'd1,
      ST_STREAM = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_DONE   = 3'd4
   } sched_state_e;

   // Bits needed to index n items; never less than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/window_scheduler_raster_counter.sv
// raster_counter: input column/line counter for the window scheduler.
// Advances one column per step, wraps the column at the end of a line,
// advances the line (wrapping to 0 after the last line) and toggles the
// ping-pong buffer select on every line wrap.
module raster_counter
   import img_proc_pkg::*;
#(
   parameter  int IMG_WIDTH  = 640,
   parameter  int IMG_HEIGHT = 480,
   localparam int AW         = idx_width(IMG_WIDTH),
   localparam int RW         = idx_width(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          step_i,
   output logic [AW-1:0] col_o,
   output logic [RW-1:0] line_o,
   output logic          buf_sel_o,
   output logic          line_end_o,
   output logic          wrap_o
);

   logic [AW-1:0] col_q, col_d;
   logic [RW-1:0] line_q, line_d;
   logic          buf_sel_q, buf_sel_d;
   logic          at_last_col;
   logic          at_last_line;

   assign at_last_col  = (col_q == AW'(IMG_WIDTH - 1));
   assign at_last_line = (line_q == RW'(IMG_HEIGHT - 1));

   // line_end_o: this step finishes a line; wrap_o: it also finishes the frame.
   assign line_end_o = step_i && at_last_col;
   assign wrap_o     = line_end_o && at_last_line;

   assign col_o     = col_q;
   assign line_o    = line_q;
   assign buf_sel_o = buf_sel_q;

   // Next counter values: clear on frame start, otherwise advance on each step.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      col_d     = col_q;
      line_d    = line_q;
      buf_sel_d = buf_sel_q;
      if (clr_i) begin
         col_d     = '0;
         line_d    = '0;
         buf_sel_d = 1'b0;
      end else if (step_i) begin
         if (at_last_col) begin
            col_d     = '0;
            line_d    = at_last_line ? '0 : line_q + RW'(1);
            buf_sel_d = ~buf_sel_q;
         end else begin
            col_d = col_q + AW'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         col_q     <= '0;
         line_q    <= '0;
         buf_sel_q <= 1'b0;
      end else begin
         col_q     <= col_d;
         line_q    <= line_d;
         buf_sel_q <= buf_sel_d;
      end
   end

endmodule

// File: rtl/window_scheduler.sv
// window_scheduler: accepts a raster pixel stream, writes each pixel into the
// line cache one cycle after it arrives, and presents window-centre positions
// on a valid/ready handshake. Line 0 only primes the cache; windows start on
// line 1 with row = input line - 1.
// Build option: define SCHED_FLUSH_EN to add the FLUSH state, which emits one
// extra window row (row IMG_HEIGHT-1) after the last input pixel.
module window_scheduler
   import img_proc_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int IMG_WIDTH  = 640,
   parameter  int IMG_HEIGHT = 480,
   localparam int AW         = idx_width(IMG_WIDTH),
   localparam int RW         = idx_width(IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  cache_we,
   output logic [AW-1:0]         cache_addr,
   output logic [DATA_WIDTH-1:0] cache_pixel,
   output logic                  buf_sel,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [AW-1:0]         col,
   output logic [RW-1:0]         row,
   output logic                  busy,
   output logic                  frame_done
);

   sched_state_e          state_q, state_d;
   logic                  xfer;
   logic                  start_frame;
   logic [AW-1:0]         in_col;
   logic [RW-1:0]         in_line;
   logic                  line_end;
   logic                  frame_end;

   logic                  cache_we_q, cache_we_d;
   logic [AW-1:0]         cache_addr_q, cache_addr_d;
   logic [DATA_WIDTH-1:0] cache_pixel_q, cache_pixel_d;
   logic                  win_valid_q, win_valid_d;
   logic [AW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;

   assign xfer        = s_valid && s_ready;
   assign start_frame = (state_q == ST_IDLE) && start;

   raster_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_raster (
      .clk        (clk),
      .rst_n      (rst),
      .clr_i      (start_frame),
      .step_i     (xfer),
      .col_o      (in_col),
      .line_o     (in_line),
      .buf_sel_o  (buf_sel),
      .line_end_o (line_end),
      .wrap_o     (frame_end)
   );

`ifdef SCHED_FLUSH_EN
   logic [AW-1:0] flush_col_q, flush_col_d;
   logic          flush_load;
   logic          flush_last;

   // A flush window loads whenever the output slot is empty or being drained.
   assign flush_load = (state_q == ST_FLUSH) && (!win_valid_q || win_ready);
   assign flush_last = (flush_col_q == AW'(IMG_WIDTH - 1));

   // Flush column: held at 0 outside FLUSH, advances per loaded window.
   always_comb begin
      flush_col_d = flush_col_q;
      if (state_q != ST_FLUSH) begin
         flush_col_d = '0;
      end else if (flush_load) begin
         flush_col_d = flush_col_q + AW'(1);
      end
   end

   // Flush column register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_col_q <= '0;
      end else begin
         flush_col_q <= flush_col_d;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; start only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_PRIME;
         ST_PRIME:  if (line_end) state_d = ST_STREAM;
         ST_STREAM: begin
            if (frame_end) begin
`ifdef SCHED_FLUSH_EN
               state_d = ST_FLUSH;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef SCHED_FLUSH_EN
         ST_FLUSH:  if (flush_load && flush_last) state_d = ST_DONE;
`endif
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: input backpressure follows the window consumer while streaming.
   always_comb begin
      s_ready    = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE:   busy = 1'b0;
         ST_PRIME:  s_ready = 1'b1;
         ST_STREAM: s_ready = win_ready;
         ST_DONE:   frame_done = 1'b1;
         default:   s_ready = 1'b0;
      endcase
   end

   // Cache write and window slot next values; a streaming transfer only happens
   // with win_ready high, so loading a new window also retires the old one.
   always_comb begin
      cache_we_d    = xfer;
      cache_addr_d  = cache_addr_q;
      cache_pixel_d = cache_pixel_q;
      if (xfer) begin
         cache_addr_d  = in_col;
         cache_pixel_d = s_data;
      end

      win_valid_d = win_valid_q;
      col_d       = col_q;
      row_d       = row_q;
      if (xfer && (state_q == ST_STREAM)) begin
         win_valid_d = 1'b1;
         col_d       = in_col;
         row_d       = in_line - RW'(1);
      end
`ifdef SCHED_FLUSH_EN
      else if (flush_load) begin
         win_valid_d = 1'b1;
         col_d       = flush_col_q;
         row_d       = RW'(IMG_HEIGHT - 1);
      end
`endif
      else if (win_ready) begin
         win_valid_d = 1'b0;
      end
   end

   // Cache write and window slot registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_we_q    <= 1'b0;
         cache_addr_q  <= '0;
         cache_pixel_q <= '0;
         win_valid_q   <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
      end else begin
         cache_we_q    <= cache_we_d;
         cache_addr_q  <= cache_addr_d;
         cache_pixel_q <= cache_pixel_d;
         win_valid_q   <= win_valid_d;
         col_q         <= col_d;
         row_q         <= row_d;
      end
   end

   assign cache_we    = cache_we_q;
   assign cache_addr  = cache_addr_q;
   assign cache_pixel = cache_pixel_q;
   assign win_valid   = win_valid_q;
   assign col         = col_q;
   assign row         = row_q;

endmodule
